// File: rtl/writeback_checker.sv
// writeback_checker: snoops the CPU register-file write-back port and checks each
// architectural write, in order, against a preloaded table of {register, value}
// pairs. Reports pass, mismatch, timeout or configuration error and counts RUN cycles.

// Expected-value table: one address/data pair per slot, written only from IDLE.
// Out-of-range slot indices are dropped by the decode rather than aliased.
module writeback_checker_table #(
    parameter int AW           = 5,
    parameter int DATA_WIDTH   = 32,
    parameter int EXPECT_DEPTH = 64,
    parameter int IW           = 7,
    parameter int XW           = 6
) (
    input  logic                  clock,
    input  logic                  wr_en,
    input  logic [IW-1:0]         wr_index,
    input  logic [AW-1:0]         wr_address,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [XW-1:0]         rd_index,
    output logic [AW-1:0]         rd_address,
    output logic [DATA_WIDTH-1:0] rd_data
);
    localparam logic [IW-1:0] DEPTH_L = IW'(EXPECT_DEPTH);

    logic [AW-1:0]         addr_mem [EXPECT_DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [EXPECT_DEPTH];
    logic                  wr_hit;

    assign wr_hit = wr_en && (wr_index < DEPTH_L);

    // Table storage; intentionally unreset so a reset between runs keeps the contents
    always_ff @(posedge clock) begin
        if (wr_hit) begin
            addr_mem[wr_index[XW-1:0]] <= wr_address;
            data_mem[wr_index[XW-1:0]] <= wr_data;
        end
    end

    assign rd_address = addr_mem[rd_index];
    assign rd_data    = data_mem[rd_index];
endmodule

// state | meaning
// IDLE  | table loadable, waiting for start
// RUN   | checking write-backs against the table, counting cycles
// PASS  | every expected write matched (terminal until reset)
// FAIL  | mismatch, timeout or bad expect_count (terminal until reset)
module writeback_checker #(
    parameter int REG_COUNT    = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int EXPECT_DEPTH = 64,
    parameter int TIMEOUT      = 1000,
    parameter int CW           = 32,
    localparam int AW          = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1,
    localparam int IW          = $clog2(EXPECT_DEPTH + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load_enable,
    input  logic [IW-1:0]         load_index,
    input  logic [AW-1:0]         load_address,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic [IW-1:0]         expect_count,
    input  logic                  start,
    input  logic                  write_enable,
    input  logic [AW-1:0]         write_address,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [1:0]            fail_code,
    output logic [IW-1:0]         fail_index,
    output logic [DATA_WIDTH-1:0] fail_data,
    output logic [IW-1:0]         match_count,
    output logic [CW-1:0]         cycle_count
);
    localparam int XW = (EXPECT_DEPTH > 1) ? $clog2(EXPECT_DEPTH) : 1;
    // Timeout is a down-counter loaded on start; terminal count marks cycle TIMEOUT-1
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT - 1);
    localparam logic [IW-1:0] DEPTH_L    = IW'(EXPECT_DEPTH);

    localparam logic [1:0] FC_NONE     = 2'd0;
    localparam logic [1:0] FC_MISMATCH = 2'd1;
    localparam logic [1:0] FC_TIMEOUT  = 2'd2;
    localparam logic [1:0] FC_CONFIG   = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PASS = 2'd2,
        FAIL = 2'd3
    } state_t;

    state_t                state, state_n;
    logic [IW-1:0]         exp_count, exp_count_n;
    logic [TW-1:0]         timer, timer_n;
    logic                  busy_n, done_n, pass_n;
    logic [1:0]            fail_code_n;
    logic [IW-1:0]         fail_index_n;
    logic [DATA_WIDTH-1:0] fail_data_n;
    logic [IW-1:0]         match_count_n;
    logic [CW-1:0]         cycle_count_n;

    logic                  table_wr;
    logic [AW-1:0]         exp_address;
    logic [DATA_WIDTH-1:0] exp_data;
    logic                  wr_event;
    logic                  entry_hit;
    logic [IW-1:0]         match_inc;

    assign table_wr  = load_enable && (state == IDLE);
    assign wr_event  = write_enable && (write_address != '0);
    assign entry_hit = (exp_address == write_address) && (exp_data == write_data);
    assign match_inc = match_count + IW'(1);

    writeback_checker_table #(
        .AW           (AW),
        .DATA_WIDTH   (DATA_WIDTH),
        .EXPECT_DEPTH (EXPECT_DEPTH),
        .IW           (IW),
        .XW           (XW)
    ) u_table (
        .clock      (clock),
        .wr_en      (table_wr),
        .wr_index   (load_index),
        .wr_address (load_address),
        .wr_data    (load_data),
        .rd_index   (match_count[XW-1:0]),
        .rd_address (exp_address),
        .rd_data    (exp_data)
    );

    // Next-state and next-output decode; every output register is fed from here
    always_comb begin
        state_n       = state;
        exp_count_n   = exp_count;
        timer_n       = timer;
        fail_code_n   = fail_code;
        fail_index_n  = fail_index;
        fail_data_n   = fail_data;
        match_count_n = match_count;
        cycle_count_n = cycle_count;

        case (state)
            IDLE: begin
                if (start) begin
                    if (expect_count > DEPTH_L) begin
                        state_n      = FAIL;
                        fail_code_n  = FC_CONFIG;
                        fail_index_n = expect_count;
                    end else if (expect_count == '0) begin
                        state_n = PASS;
                    end else begin
                        state_n       = RUN;
                        exp_count_n   = expect_count;
                        timer_n       = TIMER_LOAD;
                        match_count_n = '0;
                        cycle_count_n = '0;
                    end
                end
            end

            RUN: begin
                cycle_count_n = cycle_count + CW'(1);
                if (timer != '0) begin
                    timer_n = timer - TW'(1);
                end

                // A completing match beats a mismatch, which beats the timeout
                if (wr_event && entry_hit) begin
                    match_count_n = match_inc;
                    if (match_inc == exp_count) begin
                        state_n = PASS;
                    end
                end else if (wr_event) begin
                    state_n      = FAIL;
                    fail_code_n  = FC_MISMATCH;
                    fail_index_n = match_count;
                    fail_data_n  = write_data;
                end

                if ((state_n == RUN) && (timer == '0)) begin
                    state_n      = FAIL;
                    fail_code_n  = FC_TIMEOUT;
                    fail_index_n = match_count_n;
                end
            end

            default: begin
                // PASS and FAIL hold everything until reset
            end
        endcase

        busy_n = (state_n == RUN);
        done_n = (state_n == PASS) || (state_n == FAIL);
        pass_n = (state_n == PASS);
    end

    // State and registered outputs; asynchronous reset clears them all
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            exp_count   <= '0;
            timer       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail_code   <= FC_NONE;
            fail_index  <= '0;
            fail_data   <= '0;
            match_count <= '0;
            cycle_count <= '0;
        end else begin
            state       <= state_n;
            exp_count   <= exp_count_n;
            timer       <= timer_n;
            busy        <= busy_n;
            done        <= done_n;
            pass        <= pass_n;
            fail_code   <= fail_code_n;
            fail_index  <= fail_index_n;
            fail_data   <= fail_data_n;
            match_count <= match_count_n;
            cycle_count <= cycle_count_n;
        end
    end
endmodule

// File: doc/writeback_checker.md
Name: writeback_checker

Overview:
- Self-checking monitor for SOPC simulation and FPGA bring-up.
- Snoops the CPU register-file write-back port and compares each architectural write against an ordered table of expected {register, value} pairs.
- Reports pass, mismatch, timeout or configuration error, with a cycle budget.
- Replaces manual waveform inspection of register dumps; parametrised for register count, data width, table depth and timeout.

Parameters:
- REG_COUNT, 32: number of architectural registers; address width AW = clog2(REG_COUNT).
- DATA_WIDTH, 32: register data width.
- EXPECT_DEPTH, 64: expected-table entries; index width IW = clog2(EXPECT_DEPTH+1).
- TIMEOUT, 1000: maximum RUN cycles before timeout failure; must be at least 1.
- CW, 32: width of cycle counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- load_enable  in  1  write one expected-table entry (IDLE only).
- load_index  in  IW  table slot being written.
- load_address  in  AW  expected destination register.
- load_data  in  DATA_WIDTH  expected value.
- expect_count  in  IW  number of entries to check; sampled on start.
- start  in  1  one-cycle pulse, arms the checker.
- write_enable  in  1  register-file write strobe from CPU.
- write_address  in  AW  register-file write address.
- write_data  in  DATA_WIDTH  register-file write data.
- busy  out  1  high in RUN.
- done  out  1  high in PASS or FAIL.
- pass  out  1  high in PASS.
- fail_code  out  2  0 none, 1 mismatch, 2 timeout, 3 config error.
- fail_index  out  IW  table index at failure.
- fail_data  out  DATA_WIDTH  offending write_data on mismatch, else 0.
- match_count  out  IW  entries matched so far.
- cycle_count  out  CW  RUN cycles elapsed.

Behaviour:
- States: IDLE, RUN, PASS, FAIL. All outputs are registered.
- Reset (asynchronous, any time, including mid-RUN): state goes to IDLE; every output is 0.
  - Table contents are not cleared; the table is plain memory without reset.
- IDLE:
  - load_enable with load_index < EXPECT_DEPTH writes the entry; out-of-range indices are ignored.
  - start leads to one of:
    - expect_count > EXPECT_DEPTH: FAIL, code 3, fail_index = expect_count.
    - expect_count == 0: PASS.
    - otherwise: RUN; match_count and cycle_count cleared to 0.
- load_enable outside IDLE is ignored. start outside IDLE is ignored.
- RUN, per cycle:
  - cycle_count increments by 1.
  - A write event is write_enable high and write_address != 0. Writes to register 0 are never checked.
  - On a write event, compare against entry[match_count]:
    - address and data equal: match_count increments; if the new match_count == expect_count, next state is PASS.
    - either field differs: next state FAIL, code 1, fail_index = match_count, fail_data = write_data.
  - Timeout: if cycle_count == TIMEOUT-1 and no PASS/FAIL transition occurs this cycle, next state FAIL, code 2, fail_index = match_count.
  - Priority within one cycle: completing match > mismatch > timeout.
- Latency: a write sampled at edge N is reflected in match_count, done, pass and fail_* after edge N.
- PASS and FAIL are terminal until reset.
  - Further writes, start and load_enable are ignored.
  - All outputs hold, and cycle_count freezes.
- At most one write event is checked per cycle; back-to-back writes on consecutive cycles are each checked.

Test Plan:
- Load 3 entries {r1=0x1100, r2=0x0020, r3=0x1120}, expect_count=3, start; CPU writes them in order, one per 2 cycles, with a write to r0 in between -> pass=1, done=1, fail_code=0, match_count=3.
- Same table; second write is r2=0x0021 -> fail_code=1, fail_index=1, fail_data=0x0021, match_count=1; later writes ignored.
- TIMEOUT=10, expect_count=2, only one matching write -> after 10 RUN cycles: fail_code=2, fail_index=1, cycle_count=10.
- Final expected write lands on the cycle where cycle_count==TIMEOUT-1 -> PASS, not timeout.
- expect_count=0 -> PASS one cycle after start. expect_count=EXPECT_DEPTH+1 -> fail_code=3.
- Assert reset mid-RUN after 1 match -> all outputs 0 immediately (asynchronous); re-start without reloading -> full pass using the retained table.
